// File: rtl/serial_word_host.sv
// Host side of the bit-serial link: serialises a parallel operand LSB-first and
// reassembles the peer's serial result into a parallel word, both on valid/ready.
module serial_word_host #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_data,
  output logic             tx_start,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (op_valid) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh <= '0;
      rx_sh <= '0;
      cnt   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (op_valid) begin
            tx_sh <= op_data;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          tx_sh <= {1'b0, tx_sh[WIDTH-1:1]};
          rx_sh <= {ser_in, rx_sh[WIDTH-1:1]};
          // Explicit clear keeps the counter in range for non-power-of-two widths.
          cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // rx_sh is frozen outside SHIFT, so the result survives the handshake.
  assign op_ready  = (state_reg == IDLE);
  assign tx_start  = (state_reg == SHIFT) && (cnt == '0);
  assign ser_out   = (state_reg == SHIFT) && tx_sh[0];
  assign res_valid = (state_reg == HOLD);
  assign res_data  = rx_sh;

endmodule

// File: tb/tb_serial_word_host.sv
// Directed bench for serial_word_host (WIDTH=4) with a loopback or serial +1 peer.
module tb_serial_word_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_data;
  logic       tx_start;
  logic       ser_out;
  logic       ser_in;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_ready;

  logic peer_incr;
  logic carry;
  logic c_eff;

  int checks = 0;
  int errors = 0;

  serial_word_host #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .tx_start  (tx_start),
    .ser_out   (ser_out),
    .ser_in    (ser_in),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  // Peer: loopback, or a serial incrementer whose carry-in is forced at tx_start.
  assign c_eff  = tx_start | carry;
  assign ser_in = peer_incr ? (ser_out ^ c_eff) : ser_out;
  always @(posedge clk) carry <= ser_out & c_eff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [3:0] d, input logic [3:0] exp_res);
    op_valid = 1'b1;
    op_data  = d;
    step();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("frame%0h_tx_start_b%0d", d, i), 32'(tx_start), 32'(i == 0));
      chk($sformatf("frame%0h_ser_out_b%0d", d, i), 32'(ser_out), 32'(d[i]));
      step();
    end
    chk($sformatf("frame%0h_res_valid", d), 32'(res_valid), 32'd1);
    chk($sformatf("frame%0h_res_data", d), 32'(res_data), 32'(exp_res));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk($sformatf("frame%0h_op_ready_after", d), 32'(op_ready), 32'd1);
    chk($sformatf("frame%0h_res_valid_after", d), 32'(res_valid), 32'd0);
  endtask

  initial begin
    int last_start;
    int nstart;
    int nres;
    logic seen_valid;

    reset     = 1'b1;
    op_valid  = 1'b0;
    op_data   = 4'h0;
    res_ready = 1'b0;
    peer_incr = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    step();

    // Reset asserted while idle, held for two cycles
    reset = 1'b1;
    step();
    step();
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    reset = 1'b0;
    step();
    $display("txn reset: done");

    // Loopback 4'hA with explicit bit checks, then backpressure in HOLD
    op_valid = 1'b1;
    op_data  = 4'hA;
    step();
    op_valid = 1'b0;
    chk("lb_tx_start_b0", 32'(tx_start), 32'd1);
    chk("lb_ser_out_b0", 32'(ser_out), 32'd0);
    chk("lb_op_ready_shift", 32'(op_ready), 32'd0);
    step();
    chk("lb_tx_start_b1", 32'(tx_start), 32'd0);
    chk("lb_ser_out_b1", 32'(ser_out), 32'd1);
    step();
    chk("lb_ser_out_b2", 32'(ser_out), 32'd0);
    step();
    chk("lb_ser_out_b3", 32'(ser_out), 32'd1);
    step();
    chk("lb_res_valid", 32'(res_valid), 32'd1);
    chk("lb_res_data", 32'(res_data), 32'hA);
    $display("txn loopback op=a res=%0h", res_data);
    op_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op_data = 4'(k + 3);
      step();
      chk($sformatf("bp_res_valid_%0d", k), 32'(res_valid), 32'd1);
      chk($sformatf("bp_res_data_%0d", k), 32'(res_data), 32'hA);
      chk($sformatf("bp_op_ready_%0d", k), 32'(op_ready), 32'd0);
      chk($sformatf("bp_tx_start_%0d", k), 32'(tx_start), 32'd0);
    end
    res_ready = 1'b1;
    step();
    op_valid  = 1'b0;
    res_ready = 1'b0;
    chk("bp_op_ready_release", 32'(op_ready), 32'd1);
    chk("bp_res_valid_release", 32'(res_valid), 32'd0);
    chk("bp_res_data_kept", 32'(res_data), 32'hA);
    $display("txn backpressure: released");

    // Incrementing peer
    peer_incr = 1'b1;
    do_frame(4'h7, 4'h8);
    $display("txn incr op=7 res=%0h", res_data);
    do_frame(4'hF, 4'h0);
    $display("txn incr op=f res=%0h", res_data);

    // Reset mid-frame on 4'h5 after bit 1
    op_valid = 1'b1;
    op_data  = 4'h5;
    step();
    op_valid = 1'b0;
    step();
    step();
    chk("mid_ser_out_b2", 32'(ser_out), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_ser_out_drop", 32'(ser_out), 32'd0);
    chk("mid_tx_start_drop", 32'(tx_start), 32'd0);
    chk("mid_op_ready", 32'(op_ready), 32'd1);
    step();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (res_valid || tx_start) seen_valid = 1'b1;
    end
    chk("mid_no_partial", 32'(seen_valid), 32'd0);
    do_frame(4'h3, 4'h4);
    $display("txn reset-midframe then op=3 res=%0h", res_data);

    // Back-to-back with op_valid and res_ready held high
    op_valid   = 1'b1;
    op_data    = 4'h1;
    res_ready  = 1'b1;
    nstart     = 0;
    nres       = 0;
    last_start = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      if (tx_start) begin
        if (nstart > 0) chk($sformatf("b2b_period_%0d", nstart), 32'(cyc - last_start), 32'd6);
        last_start = cyc;
        nstart++;
        if (nstart < 3) op_data = 4'(nstart + 1);
        else op_valid = 1'b0;
      end
      if (res_valid) begin
        chk($sformatf("b2b_res_%0d", nres), 32'(res_data), 32'(nres + 2));
        $display("txn b2b res=%0h", res_data);
        nres++;
      end
    end
    chk("b2b_frames", 32'(nstart), 32'd3);
    chk("b2b_results", 32'(nres), 32'd3);
    res_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
